// File: rtl/residue.sv
// residue: 2^nn mod M by shift/conditional-subtract over an ADW-addressed word memory (addr 0 = MSW).
// Latency 1 + length + sum(iterations) + 1 cycles; calculate is ignored while busy, no backpressure.
module residue #(
  parameter int ADW = 8,
  parameter int OPW = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           calculate,
  output logic           ready,
  input  logic [ADW-1:0] length,
  input  logic [15:0]    nn,
  output logic [ADW-1:0] opm_addr,
  input  logic [OPW-1:0] opm_data,
  output logic [ADW-1:0] opa_rd_addr,
  input  logic [OPW-1:0] opa_rd_data,
  output logic [ADW-1:0] opa_wr_addr,
  output logic [OPW-1:0] opa_wr_data,
  output logic           opa_wr_we
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LOOP, S_SHIFT, S_CMP, S_SUB, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [ADW-1:0] len_q, len_d;
  logic [ADW-1:0] idx_q, idx_d;
  logic [15:0]    nn_q, nn_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           cy_q, cy_d;
  logic           ready_q, ready_d;

  logic [ADW-1:0] len_m1;
  logic [OPW:0]   diff;

  assign len_m1 = len_q - ADW'(1);
  assign diff   = {1'b0, opa_rd_data} - {1'b0, opm_data} - {{OPW{1'b0}}, cy_q};
  assign ready  = ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      nn_q    <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      nn_q    <= nn_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    nn_d        = nn_q;
    cnt_d       = cnt_q;
    cy_d        = cy_q;
    ready_d     = ready_q;
    opm_addr    = '0;
    opa_rd_addr = '0;
    opa_wr_addr = '0;
    opa_wr_data = '0;
    opa_wr_we   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (calculate) begin
          ready_d = 1'b0;
          len_d   = length;
          nn_d    = nn;
          cnt_d   = '0;
          cy_d    = 1'b0;
          idx_d   = length - ADW'(1);
          state_d = (length == '0) ? S_DONE : S_INIT;
        end
      end

      S_INIT: begin
        opa_rd_addr = idx_q;
        opa_wr_addr = idx_q;
        opa_wr_we   = 1'b1;
        opa_wr_data = (idx_q == len_m1) ? OPW'(1) : '0;
        if (idx_q == '0) state_d = S_LOOP;
        else             idx_d   = idx_q - ADW'(1);
      end

      S_LOOP: begin
        if (cnt_q == nn_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
          idx_d   = len_m1;
          cy_d    = 1'b0;
        end
      end

      S_SHIFT: begin
        opa_rd_addr = idx_q;
        opa_wr_addr = idx_q;
        opa_wr_we   = 1'b1;
        opa_wr_data = {opa_rd_data[OPW-2:0], cy_q};
        cy_d        = opa_rd_data[OPW-1];
        if (idx_q == '0) begin
          cnt_d = cnt_q + 16'd1;
          // A shifted-out bit means the value already exceeds M: subtract without comparing.
          if (opa_rd_data[OPW-1]) begin
            state_d = S_SUB;
            idx_d   = len_m1;
            cy_d    = 1'b0;
          end else begin
            state_d = S_CMP;
            idx_d   = '0;
          end
        end else begin
          idx_d = idx_q - ADW'(1);
        end
      end

      S_CMP: begin
        opm_addr    = idx_q;
        opa_rd_addr = idx_q;
        opa_wr_addr = idx_q;
        if (opa_rd_data > opm_data || (opa_rd_data == opm_data && idx_q == len_m1)) begin
          state_d = S_SUB;
          idx_d   = len_m1;
          cy_d    = 1'b0;
        end else if (opa_rd_data < opm_data) begin
          state_d = S_LOOP;
        end else begin
          idx_d = idx_q + ADW'(1);
        end
      end

      S_SUB: begin
        opm_addr    = idx_q;
        opa_rd_addr = idx_q;
        opa_wr_addr = idx_q;
        opa_wr_we   = 1'b1;
        opa_wr_data = diff[OPW-1:0];
        cy_d        = diff[OPW];
        if (idx_q == '0) state_d = S_LOOP;
        else             idx_d   = idx_q - ADW'(1);
      end

      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_residue.sv
// Bench for residue: memory models for opa/opm, expected result words queued at start, compared after ready.
module tb_residue;

  logic        clk = 1'b0;
  logic        reset;
  logic        calculate;
  logic        ready;
  logic [7:0]  length;
  logic [15:0] nn;
  logic [7:0]  opm_addr;
  logic [31:0] opm_data;
  logic [7:0]  opa_rd_addr;
  logic [31:0] opa_rd_data;
  logic [7:0]  opa_wr_addr;
  logic [31:0] opa_wr_data;
  logic        opa_wr_we;

  logic [31:0] mem_a [0:255];
  logic [31:0] mem_m [0:255];
  int          wr_cnt = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];

  localparam logic [127:0] M2 = 128'hFFFFFFFF_FFFFFFC5;

  residue dut (
    .clk(clk), .reset(reset), .calculate(calculate), .ready(ready),
    .length(length), .nn(nn),
    .opm_addr(opm_addr), .opm_data(opm_data),
    .opa_rd_addr(opa_rd_addr), .opa_rd_data(opa_rd_data),
    .opa_wr_addr(opa_wr_addr), .opa_wr_data(opa_wr_data), .opa_wr_we(opa_wr_we)
  );

  always #5 clk = ~clk;

  assign opa_rd_data = mem_a[opa_rd_addr];
  assign opm_data    = mem_m[opm_addr];

  always @(posedge clk) begin
    if (opa_wr_we) begin
      mem_a[opa_wr_addr] <= opa_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] m, input int nnv);
    logic [159:0] r;
    r = 160'd1;
    for (int k = 0; k < nnv; k++) begin
      r = r << 1;
      if (r >= {32'd0, m}) r = r - {32'd0, m};
    end
    return r[127:0];
  endfunction

  task automatic start_run(input int len, input logic [127:0] m, input int nnv,
                           input logic [127:0] exp_val, input bit push_exp);
    @(negedge clk);
    for (int i = 0; i < 256; i++) mem_a[i] <= 32'hDEADBEEF;
    for (int i = 0; i < len; i++) mem_m[i] = m[32*(len-1-i) +: 32];
    length    = 8'(len);
    nn        = 16'(nnv);
    calculate = 1'b1;
    if (push_exp)
      for (int i = 0; i < len; i++) exp_q.push_back(exp_val[32*(len-1-i) +: 32]);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      calculate = 1'b0;
    end while (!ready && cyc < 20000);
    if (!ready) check("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  task automatic compare_result(input string tag);
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      check(tag, mem_a[i], exp_q.pop_front());
      i++;
    end
  endtask

  initial begin
    int cyc;
    int w0;
    logic [127:0] m;
    int len;
    int nnv;

    reset = 1'b1; calculate = 1'b0; length = '0; nn = '0;
    for (int i = 0; i < 256; i++) mem_m[i] = 32'd0;
    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_we", {31'd0, opa_wr_we}, 32'd0);
    check("rst_addr", {8'd0, opm_addr, opa_rd_addr, opa_wr_addr}, 32'd0);
    check("rst_wdata", opa_wr_data, 32'd0);
    reset = 1'b0;

    start_run(1, 128'h0000000B, 64, 128'h5, 1'b1);
    wait_done(cyc);
    compare_result("len1_nn64");

    start_run(2, M2, 64, 128'h3B, 1'b1);
    wait_done(cyc);
    compare_result("len2_nn64");

    start_run(2, M2, 128, 128'hD99, 1'b1);
    wait_done(cyc);
    compare_result("len2_nn128");

    start_run(4, 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6979, 0, 128'h1, 1'b1);
    wait_done(cyc);
    check("nn0_latency", 32'(cyc), 32'd7);
    compare_result("nn0_len4");

    w0 = wr_cnt;
    start_run(0, 128'h0, 5, 128'h0, 1'b0);
    wait_done(cyc);
    check("len0_latency", 32'(cyc), 32'd2);
    check("len0_writes", 32'(wr_cnt - w0), 32'd0);

    // second calculate pulse with a different nn while busy must be ignored
    start_run(2, M2, 64, 128'h3B, 1'b1);
    @(negedge clk);
    calculate = 1'b0;
    repeat (10) @(negedge clk);
    calculate = 1'b1;
    nn = 16'd5;
    wait_done(cyc);
    compare_result("midrun_ignored");

    // asynchronous reset while subtracting (SUB is the only writing state that drives opm_addr)
    start_run(2, M2, 128, 128'h0, 1'b0);
    cyc = 0;
    do begin
      @(negedge clk);
      calculate = 1'b0;
      cyc++;
    end while (!(opa_wr_we && opm_addr == 8'd1) && cyc < 20000);
    check("sub_reached", {31'd0, opa_wr_we}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_ready", {31'd0, ready}, 32'd1);
    check("async_we", {31'd0, opa_wr_we}, 32'd0);
    w0 = wr_cnt;
    repeat (3) @(negedge clk);
    check("reset_writes", 32'(wr_cnt - w0), 32'd0);
    reset = 1'b0;
    start_run(2, M2, 128, 128'hD99, 1'b1);
    wait_done(cyc);
    compare_result("after_reset");

    for (int t = 0; t < 3; t++) begin
      len = 2 + (t % 2);
      m = '0;
      for (int i = 0; i < len; i++) m = (m << 32) | {96'd0, 32'($urandom)};
      m[0] = 1'b1;
      m[32*len-1] = 1'b1;
      nnv = int'($urandom_range(1, 100));
      start_run(len, m, nnv, model(m, nnv), 1'b1);
      wait_done(cyc);
      compare_result("random");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
